// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns fetch PC, one outstanding imem request, DEPTH-entry {pc,instr} queue.
// Latency: grant at N, response at N+k, entry on valid_D at N+k+1; no bypass from imem_rdata.
// Backpressure: stall_D holds the head; requests stop while the queue is full; redirect flushes everything.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_F,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall_D,
    output logic                     valid_D,
    output logic [31:0]              instr_D,
    output logic [31:0]              pc_D,
    output logic [31:0]              pc_plus4_D,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_pc_q;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [63:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [63:0]     w_head;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ~stall_D & ~redirect;
    assign w_head  = r_mem[r_rd_ptr];

    // r_run keeps imem_req low while reset is held and for the release cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_req       = r_run & (r_state == S_IDLE) & (r_count < FULL) & ~redirect;
        case (r_state)
            S_IDLE: begin
                if (w_req && imem_gnt) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_push      = ~redirect;
                    w_state_nxt = S_IDLE;
                end else if (redirect) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_F) begin
        if (reset_F) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_pc_q     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_issue) begin
                r_pc_q     <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: every read is qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_pc_q, imem_rdata};
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_fetch_pc;
    assign valid_D    = w_valid;
    assign instr_D    = w_valid ? w_head[31:0]            : 32'h0000_0013;
    assign pc_D       = w_valid ? w_head[63:32]           : 32'h0000_0000;
    assign pc_plus4_D = w_valid ? (w_head[63:32] + 32'd4) : 32'h0000_0000;
    assign count      = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a memory responder plus a queue-based reference model of the fetch front end.
// Outputs are compared on the falling edge against the model, which then advances with the same inputs.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_F;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic        valid_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset_F     (reset_F),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_D     (stall_D),
        .valid_D     (valid_D),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .pc_plus4_D  (pc_plus4_D),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the decode stage should see, and what fetch is waiting on.
    logic [63:0] m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_tag;
    bit          m_busy;
    bit          m_stale;
    bit          m_run;

    // Memory responder state.
    bit          mem_busy;
    int          mem_wait;

    // Stimulus knobs (percentages).
    int          p_gnt, p_stall, p_redir, kmax;
    bit          use_force;
    logic [31:0] force_pc;

    int          n_vec;
    int          n_err;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_req();
        return m_run && !m_busy && (m_q.size() < DEPTH) && !redirect;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fpc    = RESET_PC;
        m_tag    = '0;
        m_busy   = 1'b0;
        m_stale  = 1'b0;
        m_run    = 1'b0;
        mem_busy = 1'b0;
        mem_wait = 0;
    endtask

    task automatic drive();
        int r;
        imem_gnt = ($urandom_range(99) < p_gnt);
        stall_D  = ($urandom_range(99) < p_stall);
        redirect = ($urandom_range(99) < p_redir);
        r = $urandom_range(3);
        case (r)
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2:       redirect_pc = 32'h0000_1002;
            default: redirect_pc = $urandom & 32'h0000_00FF;
        endcase
        if (use_force) redirect_pc = force_pc;
        imem_rdata = $urandom;
        if (mem_busy && mem_wait == 0)
            imem_rvalid = 1'b1;
        else if (!mem_busy && $urandom_range(15) == 0)
            imem_rvalid = 1'b1;   // stray response while nothing is outstanding
        else
            imem_rvalid = 1'b0;
    endtask

    task automatic check();
        bit          v;
        logic [31:0] hpc;
        logic [31:0] hin;
        v   = (m_q.size() > 0);
        hpc = v ? m_q[0][63:32] : 32'h0;
        hin = v ? m_q[0][31:0]  : 32'h0000_0013;
        chk("imem_req",   {31'b0, imem_req}, {31'b0, exp_req()});
        chk("imem_addr",  imem_addr, m_fpc);
        chk("valid_D",    {31'b0, valid_D}, {31'b0, v});
        chk("instr_D",    instr_D, hin);
        chk("pc_D",       pc_D, hpc);
        chk("pc_plus4_D", pc_plus4_D, v ? hpc + 32'd4 : 32'h0);
        chk("count",      {29'b0, count}, 32'(m_q.size()));
    endtask

    task automatic step();
        bit req;
        bit pop;
        req = exp_req();
        pop = (m_q.size() > 0) && !stall_D;
        if (redirect) begin
            m_q.delete();
            m_fpc = redirect_pc & 32'hFFFF_FFFC;
            if (m_busy) begin
                if (imem_rvalid) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy && imem_rvalid) begin
                if (!m_stale) m_q.push_back({m_tag, imem_rdata});
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (req && imem_gnt) begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
                m_tag   = m_fpc;
                m_fpc   = m_fpc + 32'd4;
            end
        end
        if (mem_busy && imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy)           mem_wait--;
        if (req && imem_gnt) begin
            mem_busy = 1'b1;
            mem_wait = $urandom_range(kmax - 1);
        end
        m_run = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check();
        step();
        cyc++;
    endtask

    // Reset asserted mid-cycle, held two edges, released one step after an edge.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset_F     = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        redirect    = 1'b0;
        stall_D     = 1'b0;
        model_reset();
        @(negedge clk);
        check();
        repeat (2) @(posedge clk);
        #1;
        reset_F = 1'b0;
        drive();
        @(negedge clk);
        check();
        step();
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        reset_F = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; stall_D = 1'b0;
        use_force = 1'b0; force_pc = '0;
        p_gnt = 100; p_stall = 0; p_redir = 0; kmax = 1;
        model_reset();
        apply_reset();

        // Back-to-back fetch with immediate grant and k=1.
        repeat (12) cycle();
        // Decode stalled: queue fills and requests stop.
        p_stall = 100;
        repeat (20) cycle();
        // Release: drain in PC order, refill.
        p_stall = 0;
        repeat (12) cycle();

        // Mixed random traffic with redirects and slow memory.
        p_gnt = 60; p_stall = 40; p_redir = 8; kmax = 4;
        repeat (400) cycle();

        // Redirect near the top of the address space, then run through the wrap.
        p_gnt = 100; p_stall = 0; p_redir = 100; kmax = 1;
        use_force = 1'b1; force_pc = 32'hFFFF_FFF6;
        cycle();
        use_force = 1'b0; p_redir = 0;
        repeat (14) cycle();

        // Reset in the middle of random traffic.
        p_gnt = 70; p_stall = 30; p_redir = 6; kmax = 3;
        repeat (37) cycle();
        apply_reset();
        repeat (300) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
